// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam logic LINE_IDLE = 1'b1;

  function automatic int unsigned frame_len(input int unsigned data_w,
                                            input int unsigned stop_bits,
                                            input bit          parity_en);
    return 1 + data_w + (parity_en ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_baud_tick.sv
// Rising-edge detector on the divided baud clock; the divided clock is only ever sampled as data.
module baud_tick
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic baud_clk,
  output logic tick
);

  logic baud_q, baud_d;

  always_comb baud_d = baud_clk;

  // Resetting high keeps an already-high baud_clk from looking like an edge at release.
  always_ff @(posedge clk) begin
    if (reset) baud_q <= 1'b1;
    else       baud_q <= baud_d;
  end

  assign tick = baud_clk & ~baud_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register feeding a start/data/parity/stop framer.
// Build option: define UART_TX_PARITY_EN to add one parity bit per frame.
//
// state  | meaning
// IDLE   | line high, waiting for a tick with a character held
// START  | start bit (low) on the line
// DATA   | data bits, LSB first
// PARITY | parity bit (UART_TX_PARITY_EN builds only)
// STOP   | stop bit(s), high
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              baud_clk,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy
);

  localparam int              CNT_W     = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

  if (DATA_W < 5 || DATA_W > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_tx: parameter out of range");
  end

  logic tick;

  baud_tick u_baud_tick (
    .clk      (clk),
    .reset    (reset),
    .baud_clk (baud_clk),
    .tick     (tick)
  );

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              tx_q, tx_d;
  logic              accept, load;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  always_comb begin
    accept     = tx_valid & ~hold_full_q;
    load       = 1'b0;
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    hold_d     = accept ? tx_data : hold_q;

    case (state_q)
      IDLE: if (tick && hold_full_q) begin
        load    = 1'b1;
        state_d = START;
        tx_d    = 1'b0;
      end
      START: if (tick) begin
        state_d   = DATA;
        bit_cnt_d = '0;
        tx_d      = shift_q[0];
        shift_d   = shift_q >> 1;
      end
      DATA: if (tick) begin
        if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
          state_d    = PARITY;
          tx_d       = par_q;
`else
          state_d    = STOP;
          tx_d       = LINE_IDLE;
          stop_cnt_d = STOP_LAST;
`endif
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) begin
        state_d    = STOP;
        tx_d       = LINE_IDLE;
        stop_cnt_d = STOP_LAST;
      end
`endif
      STOP: if (tick) begin
        if (stop_cnt_q == 1'b0) begin
          // A waiting character starts right away, with no idle bit in between.
          if (hold_full_q) begin
            load    = 1'b1;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = LINE_IDLE;
          end
        end else begin
          stop_cnt_d = stop_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) shift_d = hold_q;
    hold_full_d = (hold_full_q & ~load) | accept;
  end

`ifdef UART_TX_PARITY_EN
  always_comb par_d = load ? (^hold_q ^ 1'(PARITY_ODD)) : par_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      tx_q        <= LINE_IDLE;
`ifdef UART_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      tx_q        <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign tx_ready = ~hold_full_q;
  assign tx       = tx_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter for the Bluetooth module link, directly downstream of the clock counter. It consumes the counter's divided clock as a bit-rate reference, accepts bytes over a valid/ready handshake into a one-entry holding register, and shifts framed characters (start, data LSB-first, optional parity, stop) onto the `tx` line. The block runs entirely in the `clk` domain and never clocks logic from the divided clock.

## Interface
- `DATA_W`, default 8: data bits per character, legal range 5..9.
- `STOP_BITS`, default 1: stop bits per frame, 1 or 2.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Only used when parity is compiled in.

Ports:
- `clk` in 1: system clock. The only clock.
- `reset` in 1: synchronous, active-high reset.
- `baud_clk` in 1: divided clock from the clock counter. Each rising edge marks one bit period.
- `tx_data` in DATA_W: character to send.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: holding register is empty, so a character can be accepted.
- `tx` out 1: serial line. Idles high.
- `busy` out 1: a frame is in progress.

## Operation
- **Tick generation:** `baud_q` registers `baud_clk`, and `tick = baud_clk & ~baud_q`. `baud_q` resets to 1, so a high `baud_clk` at reset release produces no tick.
- **Accept:** a character is accepted on any `clk` edge where `tx_valid & tx_ready`. The data is captured in `hold`, and `hold_full` is set.
  - `tx_ready = ~hold_full`. It is combinational from a register.
- **States:** IDLE, START, DATA, PARITY, STOP.
  - **IDLE:** on `tick & hold_full`, go to START. Load the shift register from `hold` and clear `hold_full`. `tx <= 0`.
  - **START:** on tick, go to DATA with `bit_cnt = 0`. `tx <= shift[0]`, then shift right.
  - **DATA:** on tick, if `bit_cnt == DATA_W-1`, go to PARITY (parity compiled in) or STOP. Otherwise increment `bit_cnt` and output the next bit.
  - **PARITY:** `tx` = XOR of the data bits, XOR `PARITY_ODD`. On tick, go to STOP.
  - **STOP:** `tx <= 1` for `STOP_BITS` ticks (`stop_cnt`). On the final stop tick:
    - if `hold_full`, go directly to START. `tx <= 0`, with no idle bit between frames.
    - otherwise go to IDLE.
- **Simultaneous accept and load:** if an accept and a load of `hold` into the shift register happen in the same cycle, the new character goes into `hold` and `hold_full` stays 1.
- **Between ticks:** `tx_valid` with `hold_full = 1` is ignored. `hold` is not overwritten.
- **`busy`:** `busy = (state != IDLE)`.
- **Reset at any point, including mid-frame:** `tx = 1`, `tx_ready = 1`, `busy = 0`, state IDLE, `hold` discarded, `baud_q = 1`. The frame in progress is abandoned.

## Timing
- `tx` is registered. It changes on the `clk` edge that closes the tick cycle and is visible the next cycle.
- **Start latency:** the character is accepted at edge N. The start bit begins on the first tick whose cycle is after N. A tick in the acceptance cycle itself does not start the frame.
- **Bit length:** every bit lasts exactly one `baud_clk` period, i.e. 2×`cnt_to` `clk` cycles.
- **Frame length:** 1 + `DATA_W` + P + `STOP_BITS` ticks, where P is 1 with parity compiled in, else 0.
- `tx_ready` reasserts the cycle after `hold` is loaded into the shift register.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state present and one parity bit per frame, per `PARITY_ODD`.
- `UART_TX_PARITY_EN` undefined: no PARITY state and no parity logic. DATA goes straight to STOP, and `PARITY_ODD` is ignored.

## Structure
- Package `uart_pkg` holds:
  - `typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t`
  - `localparam` idle line level = 1
  - frame-length helper function
- Sub-module `baud_tick`: the rising-edge detector on `baud_clk`, with reset value 1, producing a one-`clk`-wide `tick`.

## Test plan
All scenarios use `baud_clk` from a clock counter with `cnt_to = 4` (8-`clk` bit period).
- **Reset with `baud_clk` high:** release reset → `tx = 1`, `tx_ready = 1`, `busy = 0`, and no start bit for 3 ticks.
- **Single character:** send 0xA5, no parity → per-tick `tx` = 0,1,0,1,0,0,1,0,1,1; `busy` falls after the stop bit; 80 `clk` per frame.
- **Back-to-back:** send 0x00 then 0xFF.
  - 0xFF is accepted during frame 1, and `tx_ready` stays 0 until frame 1's stop tick.
  - Frame 2's start bit immediately follows the stop bit, with no idle tick.
- **Held valid while full:** hold `tx_valid` with `hold_full = 1` while toggling `tx_data` → no accept and `hold` unchanged; the transmitted character is the originally accepted one.
- **Reset mid-frame:** assert reset during data bit 3 → next cycle `tx = 1`, `busy = 0`, `tx_ready = 1`; the pending held character is never transmitted.
- **Parity:** with `UART_TX_PARITY_EN`, even parity, send 0x07 → parity bit 1, 11-tick frame; with `PARITY_ODD = 1` → parity bit 0. Without the macro → 10-tick frame.
